// File: rtl/activate_diff_collector.sv
// Receive side of the activation-derivative stage: takes one z bundle, streams its elements
// to a scalar derivative unit, gathers the results in order and hands the packed dz vector on.
module activate_diff_collector #(
  parameter int unsigned size            = 3,
  parameter int unsigned data_size       = 16,
  parameter int unsigned dense_type_size = 4,
  localparam int unsigned idx_w          = (size > 1) ? $clog2(size) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [dense_type_size-1:0]   dense_type,
  input  logic [data_size*size-1:0]    z,
  input  logic [31:0]                  w_layer_index,
  input  logic [31:0]                  w_row_index,
  input  logic                         is_update,
  output logic                         elem_valid,
  input  logic                         elem_ready,
  output logic [data_size-1:0]         elem_z,
  output logic [dense_type_size-1:0]   elem_dense_type,
  output logic [idx_w-1:0]             elem_index,
  input  logic                         res_valid,
  input  logic [data_size-1:0]         res_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [data_size*size-1:0]    dz_out,
  output logic [31:0]                  w_layer_index_out,
  output logic [31:0]                  w_row_index_out,
  output logic                         is_update_out,
  output logic                         busy
);

  // Counters carry one extra bit so they can sit at size without wrapping.
  localparam int unsigned cnt_w = idx_w + 1;
  localparam logic [cnt_w-1:0] size_c = cnt_w'(size);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                       state_q;
  logic [data_size*size-1:0]    z_q;
  logic [data_size*size-1:0]    dz_q;
  logic [dense_type_size-1:0]   dense_type_q;
  logic [31:0]                  layer_q;
  logic [31:0]                  row_q;
  logic                         upd_q;
  logic [cnt_w-1:0]             iss_cnt_q;
  logic [cnt_w-1:0]             res_cnt_q;
  logic                         iss_fire;
  logic                         res_take;

  assign iss_fire = (state_q == StRun) && (iss_cnt_q < size_c) && elem_ready;
  assign res_take = (state_q == StRun) && res_valid && (res_cnt_q < size_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      z_q          <= '0;
      dz_q         <= '0;
      dense_type_q <= '0;
      layer_q      <= '0;
      row_q        <= '0;
      upd_q        <= 1'b0;
      iss_cnt_q    <= '0;
      res_cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            z_q          <= z;
            dense_type_q <= dense_type;
            layer_q      <= w_layer_index;
            row_q        <= w_row_index;
            upd_q        <= is_update;
            iss_cnt_q    <= '0;
            res_cnt_q    <= '0;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (iss_fire) iss_cnt_q <= iss_cnt_q + cnt_w'(1);
          if (res_take) begin
            for (int unsigned i = 0; i < size; i++) begin
              if (res_cnt_q == cnt_w'(i)) dz_q[i*data_size +: data_size] <= res_data;
            end
            res_cnt_q <= res_cnt_q + cnt_w'(1);
            if ((res_cnt_q + cnt_w'(1)) == size_c) state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready          = (state_q == StIdle);
  assign elem_valid        = (state_q == StRun) && (iss_cnt_q < size_c);
  assign out_valid         = (state_q == StDone);
  assign busy              = (state_q != StIdle);
  assign elem_dense_type   = dense_type_q;
  assign elem_index        = elem_valid ? iss_cnt_q[idx_w-1:0] : '0;
  assign dz_out            = dz_q;
  assign w_layer_index_out = layer_q;
  assign w_row_index_out   = row_q;
  assign is_update_out     = upd_q;

  always_comb begin
    elem_z = '0;
    for (int unsigned i = 0; i < size; i++) begin
      if (elem_valid && (iss_cnt_q == cnt_w'(i))) elem_z = z_q[i*data_size +: data_size];
    end
  end

endmodule

// File: tb/tb_activate_diff_collector.sv
// Directed bench for activate_diff_collector (size=3, data_size=16) with a 1-cycle derivative
// unit model that returns elem_z + 0x100.
module tb_activate_diff_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dense_type;
  logic [47:0] z;
  logic [31:0] w_layer_index;
  logic [31:0] w_row_index;
  logic        is_update;
  logic        elem_valid;
  logic        elem_ready;
  logic [15:0] elem_z;
  logic [3:0]  elem_dense_type;
  logic [1:0]  elem_index;
  logic        res_valid;
  logic [15:0] res_data;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] dz_out;
  logic [31:0] w_layer_index_out;
  logic [31:0] w_row_index_out;
  logic        is_update_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic        pend_v;
  logic [15:0] pend_d;
  logic [15:0] iss_z[$];
  int          iss_idx[$];
  logic [3:0]  iss_dt[$];
  logic [15:0] hold_z[$];
  int          hold_idx[$];

  localparam logic [47:0] ZA  = 48'h0003_0002_0001;
  localparam logic [47:0] DZA = 48'h0103_0102_0101;
  localparam logic [47:0] ZB  = 48'h0030_0020_0010;
  localparam logic [47:0] DZB = 48'h0130_0120_0110;
  localparam logic [47:0] ZC  = 48'h0300_0200_0100;
  localparam logic [47:0] DZC = 48'h0400_0300_0200;

  always #5 clk = ~clk;

  activate_diff_collector #(
    .size(3),
    .data_size(16),
    .dense_type_size(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dense_type(dense_type),
    .z(z),
    .w_layer_index(w_layer_index),
    .w_row_index(w_row_index),
    .is_update(is_update),
    .elem_valid(elem_valid),
    .elem_ready(elem_ready),
    .elem_z(elem_z),
    .elem_dense_type(elem_dense_type),
    .elem_index(elem_index),
    .res_valid(res_valid),
    .res_data(res_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dz_out(dz_out),
    .w_layer_index_out(w_layer_index_out),
    .w_row_index_out(w_row_index_out),
    .is_update_out(is_update_out),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_z.delete();
    iss_idx.delete();
    iss_dt.delete();
    hold_z.delete();
    hold_idx.delete();
    pend_v = 1'b0;
    pend_d = '0;
  endtask

  task automatic set_bundle(input logic [47:0] zz, input logic [3:0] dt, input logic [31:0] lay,
                            input logic [31:0] row, input logic upd);
    z             = zz;
    dense_type    = dt;
    w_layer_index = lay;
    w_row_index   = row;
    is_update     = upd;
  endtask

  task automatic send_bundle(input logic [47:0] zz, input logic [3:0] dt, input logic [31:0] lay,
                             input logic [31:0] row, input logic upd);
    clear_logs();
    set_bundle(zz, dt, lay, row, upd);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // One cycle of the derivative unit: present last cycle's result, accept or stall the element.
  task automatic unit_cycle(input bit rdy);
    res_valid  = pend_v;
    res_data   = pend_d;
    elem_ready = rdy;
    #1;
    if (elem_valid && rdy) begin
      iss_z.push_back(elem_z);
      iss_idx.push_back(int'(elem_index));
      iss_dt.push_back(elem_dense_type);
    end
    pend_v = elem_valid && rdy;
    pend_d = elem_z + 16'h0100;
    tick();
  endtask

  // Counts cycles from the acceptance cycle (cycle 0) until out_valid is seen.
  task automatic run_to_done(input int stall_idx, input int stall_n, output int cyc);
    int left;
    bit rdy;
    left = stall_n;
    cyc  = 1;
    while (!out_valid && cyc < 40) begin
      rdy = 1'b1;
      if (elem_valid && int'(elem_index) == stall_idx && left > 0) begin
        rdy = 1'b0;
        left--;
        hold_z.push_back(elem_z);
        hold_idx.push_back(int'(elem_index));
      end
      unit_cycle(rdy);
      cyc++;
    end
    res_valid  = 1'b0;
    elem_ready = 1'b0;
    pend_v     = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || elem_valid !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got in_ready=%b busy=%b elem_valid=%b out_valid=%b, want 1 0 0 0",
               in_ready, busy, elem_valid, out_valid);
    end
    total++;
    if (dz_out !== 48'h0 || elem_z !== 16'h0 || elem_index !== 2'd0 || elem_dense_type !== 4'h0 ||
        w_layer_index_out !== 32'h0 || w_row_index_out !== 32'h0 || is_update_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: got dz=%h ez=%h ei=%0d edt=%h lay=%h row=%h upd=%b, want all 0",
               dz_out, elem_z, elem_index, elem_dense_type, w_layer_index_out,
               w_row_index_out, is_update_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    send_bundle(ZA, 4'd2, 32'd5, 32'd7, 1'b1);
    run_to_done(-1, 0, cyc);
    total++;
    if (iss_z.size() != 3) begin
      bad++;
      $display("FAIL basic_issue_count: got %0d, want 3", iss_z.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (iss_z[i] !== 16'(i + 1) || iss_idx[i] != i || iss_dt[i] !== 4'd2) begin
        bad++;
        $display("FAIL basic_issue%0d: got z=%h idx=%0d dt=%0d, want z=%h idx=%0d dt=2",
                 i, iss_z[i], iss_idx[i], iss_dt[i], 16'(i + 1), i);
      end
    end
    total++;
    if (cyc != 5) begin
      bad++;
      $display("FAIL basic_latency: got out_valid at cycle %0d, want 5", cyc);
    end
    total++;
    if (out_valid !== 1'b1 || dz_out !== DZA || w_layer_index_out !== 32'd5 ||
        w_row_index_out !== 32'd7 || is_update_out !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got ov=%b dz=%h lay=%0d row=%0d upd=%b ir=%b, want 1 %h 5 7 1 0",
               out_valid, dz_out, w_layer_index_out, w_row_index_out, is_update_out,
               in_ready, DZA);
    end
  endtask

  // Runs from the DONE state left by test_basic.
  task automatic test_excess_results();
    res_valid = 1'b1;
    res_data  = 16'hFFFF;
    tick();
    res_valid = 1'b0;
    total++;
    if (dz_out !== DZA || out_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL excess_result: got dz=%h ov=%b busy=%b, want %h 1 1",
               dz_out, out_valid, busy, DZA);
    end
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || dz_out !== DZA) begin
      bad++;
      $display("FAIL excess_release: got ov=%b ir=%b busy=%b dz=%h, want 0 1 0 %h",
               out_valid, in_ready, busy, dz_out, DZA);
    end
  endtask

  task automatic test_issue_backpressure();
    int cyc;
    send_bundle(ZA, 4'd2, 32'd5, 32'd7, 1'b1);
    run_to_done(1, 2, cyc);
    total++;
    if (hold_z.size() != 2) begin
      bad++;
      $display("FAIL issue_bp_stalls: got %0d stalled cycles, want 2", hold_z.size());
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (hold_z[i] !== 16'h0002 || hold_idx[i] != 1) begin
        bad++;
        $display("FAIL issue_bp_hold%0d: got z=%h idx=%0d, want z=0002 idx=1",
                 i, hold_z[i], hold_idx[i]);
      end
    end
    total++;
    if (cyc != 7 || dz_out !== DZA) begin
      bad++;
      $display("FAIL issue_bp_result: got cycle=%0d dz=%h, want 7 %h", cyc, dz_out, DZA);
    end
    release_out();
  endtask

  task automatic test_output_backpressure();
    int cyc;
    send_bundle(ZB, 4'd5, 32'd9, 32'd11, 1'b0);
    run_to_done(-1, 0, cyc);
    set_bundle(ZC, 4'd7, 32'd100, 32'd200, 1'b1);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || dz_out !== DZB || in_ready !== 1'b0 ||
          w_layer_index_out !== 32'd9) begin
        bad++;
        $display("FAIL out_bp_hold%0d: got ov=%b dz=%h ir=%b lay=%0d, want 1 %h 0 9",
                 i, out_valid, dz_out, in_ready, w_layer_index_out, DZB);
      end
    end
    in_valid = 1'b0;
    release_out();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_layer_index_out !== 32'd9 ||
        is_update_out !== 1'b0) begin
      bad++;
      $display("FAIL out_bp_release: got ov=%b ir=%b lay=%0d upd=%b, want 0 1 9 0",
               out_valid, in_ready, w_layer_index_out, is_update_out);
    end
    send_bundle(ZC, 4'd7, 32'd100, 32'd200, 1'b1);
    run_to_done(-1, 0, cyc);
    total++;
    if (cyc != 5 || dz_out !== DZC || w_layer_index_out !== 32'd100 ||
        w_row_index_out !== 32'd200 || is_update_out !== 1'b1 || iss_dt[0] !== 4'd7) begin
      bad++;
      $display("FAIL out_bp_next: got cyc=%0d dz=%h lay=%0d row=%0d upd=%b dt=%0d, want 5 %h 100 200 1 7",
               cyc, dz_out, w_layer_index_out, w_row_index_out, is_update_out, iss_dt[0], DZC);
    end
    release_out();
  endtask

  task automatic test_mid_reset();
    int cyc;
    send_bundle(ZA, 4'd2, 32'd5, 32'd7, 1'b1);
    unit_cycle(1'b1);
    rst_n      = 1'b0;
    res_valid  = 1'b0;
    elem_ready = 1'b0;
    tick();
    rst_n  = 1'b1;
    pend_v = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || elem_valid !== 1'b0 || out_valid !== 1'b0 ||
        dz_out !== 48'h0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b ir=%b ev=%b ov=%b dz=%h, want 0 1 0 0 0",
               busy, in_ready, elem_valid, out_valid, dz_out);
    end
    send_bundle(ZB, 4'd5, 32'd9, 32'd11, 1'b0);
    run_to_done(-1, 0, cyc);
    total++;
    if (cyc != 5 || dz_out !== DZB || w_layer_index_out !== 32'd9 || w_row_index_out !== 32'd11) begin
      bad++;
      $display("FAIL mid_reset_after: got cyc=%0d dz=%h lay=%0d row=%0d, want 5 %h 9 11",
               cyc, dz_out, w_layer_index_out, w_row_index_out, DZB);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cyc;
    send_bundle(ZA, 4'd2, 32'd5, 32'd7, 1'b1);
    run_to_done(-1, 0, cyc);
    set_bundle(ZB, 4'd5, 32'd9, 32'd11, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got ov=%b ir=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b ir=%b, want 1 0", busy, in_ready);
    end
    clear_logs();
    run_to_done(-1, 0, cyc);
    total++;
    if (cyc != 5 || dz_out !== DZB || w_layer_index_out !== 32'd9 || w_row_index_out !== 32'd11 ||
        is_update_out !== 1'b0 || iss_z.size() != 3) begin
      bad++;
      $display("FAIL b2b_result: got cyc=%0d dz=%h lay=%0d row=%0d upd=%b n=%0d, want 5 %h 9 11 0 3",
               cyc, dz_out, w_layer_index_out, w_row_index_out, is_update_out, iss_z.size(), DZB);
    end
    total++;
    if (iss_z[0] !== 16'h0010 || iss_z[2] !== 16'h0030 || iss_dt[1] !== 4'd5) begin
      bad++;
      $display("FAIL b2b_issue: got z0=%h z2=%h dt=%0d, want 0010 0030 5",
               iss_z[0], iss_z[2], iss_dt[1]);
    end
    release_out();
  endtask

  initial begin
    in_valid   = 1'b0;
    elem_ready = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    out_ready  = 1'b0;
    set_bundle(48'h0, 4'h0, 32'h0, 32'h0, 1'b0);
    clear_logs();
    test_reset();
    test_basic();
    test_excess_results();
    test_issue_backpressure();
    test_output_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
